// File: rtl/fb_regfile_mp_pkg.sv
// Shared widths and sweep-FSM state encodings for the multi-port register file.
package fb_regfile_mp_pkg;

  localparam int unsigned Fb32Bits = 32;

  typedef enum logic {
    FbRfInit  = 1'b0,
    FbRfReady = 1'b1
  } fb_rf_state_e;

endpackage

// File: rtl/fb_rf_scoreboard.sv
// Per-register busy bits: writeback clears, issue sets (set wins), x0 never busy.
module fb_rf_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              sb_set_i,
  input  logic [AW-1:0]     sb_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a same-cycle issue keeps the register busy.
      if (sb_set_i) busy_d[sb_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy_o[i] = en_i & busy_q[rd_addr_i[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/fb_regfile_mp.sv
// Multi-port integer register file with scoreboard and one-register-per-cycle init sweep.
// Define FB_REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module fb_regfile_mp
  import fb_regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN  = Fb32Bits,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_addr_i,
  output logic                ready_o
);

  fb_rf_state_e    state_q;
  logic [AW-1:0]   cnt_q;
  logic            ready_q;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [NRD-1:0]  byp_hit;
  logic [NRD-1:0]  sb_busy;
  logic [NWR-1:0]  wr_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FbRfInit;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        FbRfInit: begin
          if (cnt_q == AW'(NREGS - 1)) begin
            state_q <= FbRfReady;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        FbRfReady: ready_q <= 1'b1;
        default:   state_q <= FbRfInit;
      endcase
    end
  end

  always_comb begin
    wr_valid = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_valid[j] = ready_q && wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0);
    end
  end

  // Array is cleared by the sweep rather than by reset; later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == FbRfInit) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_valid[j]) mem_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    byp_hit   = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ready_q && (rd_addr_i[i*AW +: AW] != '0)) begin
        rd_data_o[i*XLEN +: XLEN] = mem_q[rd_addr_i[i*AW +: AW]];
`ifdef FB_REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wr_valid[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i[i*AW +: AW])) begin
            rd_data_o[i*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
            byp_hit[i]                = 1'b1;
          end
        end
`endif
      end
    end
  end

  fb_rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .en_i      (ready_q),
    .wr_en_i   (wr_valid),
    .wr_addr_i (wr_addr_i),
    .sb_set_i  (sb_set_i),
    .sb_addr_i (sb_addr_i),
    .rd_addr_i (rd_addr_i),
    .rd_busy_o (sb_busy)
  );

  assign rd_busy_o = sb_busy & ~byp_hit;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_fb_regfile_mp.sv
// Scoreboard-driven bench for fb_regfile_mp (default parameters, honours FB_REGFILE_BYPASS_EN).
module tb_fb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        ready;

  typedef struct {
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mdl [32];
  logic        mbusy [32];
  bit          mready;
  int          n_tests;
  int          n_fail;

  fb_regfile_mp u_dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .rd_busy_o (rd_busy),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .sb_set_i  (sb_set),
    .sb_addr_i (sb_addr),
    .ready_o   (ready)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wr_en  = 2'b00;
    sb_set = 1'b0;
  endtask

  task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
    wr_en[j]          = 1'b1;
    wr_addr[j*5 +: 5] = a;
    wr_data[j*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mdl[r]   = '0;
      mbusy[r] = 1'b0;
    end
  endtask

  function automatic exp_t predict(input int p);
    exp_t        e;
    logic [4:0]  a;
    a      = rd_addr[p*5 +: 5];
    e.data = '0;
    e.busy = 1'b0;
    if (!mready || a == 5'd0) return e;
    e.data = mdl[a];
    e.busy = mbusy[a];
`ifdef FB_REGFILE_BYPASS_EN
    for (int j = 0; j < 2; j++) begin
      if (wr_en[j] && wr_addr[j*5 +: 5] == a) begin
        e.data = wr_data[j*32 +: 32];
        e.busy = 1'b0;
      end
    end
`endif
    return e;
  endfunction

  task automatic push_reads();
    for (int p = 0; p < 2; p++) sbq.push_back(predict(p));
  endtask

  // Apply the currently driven write/issue inputs to the model, then cross the edge.
  task automatic step();
    if (mready) begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) begin
          mdl[wr_addr[j*5 +: 5]]   = wr_data[j*32 +: 32];
          mbusy[wr_addr[j*5 +: 5]] = 1'b0;
        end
      end
      if (sb_set && sb_addr != 5'd0) mbusy[sb_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset   = 1'b1;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    sb_addr = '0;
    mready  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 31; c++) begin
      rd_addr = 10'($urandom);
      @(negedge clk);
      n_tests++;
      if (ready !== 1'b0 || rd_data !== 64'd0 || rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_sweep cycle %0d: ready=%b data=%h busy=%b, want ready=0 data=0 busy=0",
                 c, ready, rd_data, rd_busy);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b, want 1", ready);
    end
    @(posedge clk);
    #1;
    mready = 1'b1;
    model_clear();
    for (int r = 0; r < 32; r++) begin
      idle();
      set_rd(0, 5'(r));
      set_rd(1, 5'(31 - r));
      push_reads();
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        e = sbq.pop_front();
        n_tests++;
        if (rd_data[p*32 +: 32] !== e.data || rd_busy[p] !== e.busy) begin
          n_fail++;
          $display("FAIL reset_regs r%0d port%0d: data=%h busy=%b, want data=%h busy=%b",
                   r, p, rd_data[p*32 +: 32], rd_busy[p], e.data, e.busy);
        end
      end
      step();
    end
  endtask

  task automatic test_write();
    exp_t e;
    for (int ph = 0; ph < 3; ph++) begin
      idle();
      case (ph)
        0: begin set_wr(0, 5'd5, 32'hDEADBEEF); set_rd(0, 5'd5); set_rd(1, 5'd0); end
        1: begin set_wr(0, 5'd0, 32'h1); set_rd(0, 5'd5); set_rd(1, 5'd5); end
        default: begin set_rd(0, 5'd0); set_rd(1, 5'd0); end
      endcase
      push_reads();
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        e = sbq.pop_front();
        n_tests++;
        if (rd_data[p*32 +: 32] !== e.data || rd_busy[p] !== e.busy) begin
          n_fail++;
          $display("FAIL write ph%0d port%0d: data=%h busy=%b, want data=%h busy=%b",
                   ph, p, rd_data[p*32 +: 32], rd_busy[p], e.data, e.busy);
        end
      end
      step();
    end
  endtask

  task automatic test_same_addr();
    exp_t e;
    for (int ph = 0; ph < 2; ph++) begin
      idle();
      if (ph == 0) begin
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
      end
      set_rd(0, 5'd7);
      set_rd(1, 5'd7);
      push_reads();
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        e = sbq.pop_front();
        n_tests++;
        if (rd_data[p*32 +: 32] !== e.data || rd_busy[p] !== e.busy) begin
          n_fail++;
          $display("FAIL same_addr ph%0d port%0d: data=%h busy=%b, want data=%h busy=%b",
                   ph, p, rd_data[p*32 +: 32], rd_busy[p], e.data, e.busy);
        end
      end
      step();
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    for (int ph = 0; ph < 8; ph++) begin
      idle();
      set_rd(0, 5'd3);
      set_rd(1, 5'd0);
      case (ph)
        0: begin sb_set = 1'b1; sb_addr = 5'd3; end
        2: set_wr(0, 5'd3, 32'h33);
        4: begin set_wr(1, 5'd3, 32'h34); sb_set = 1'b1; sb_addr = 5'd3; end
        6: begin sb_set = 1'b1; sb_addr = 5'd0; set_wr(0, 5'd3, 32'h35); end
        default: ;
      endcase
      push_reads();
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        e = sbq.pop_front();
        n_tests++;
        if (rd_data[p*32 +: 32] !== e.data || rd_busy[p] !== e.busy) begin
          n_fail++;
          $display("FAIL scoreboard ph%0d port%0d: data=%h busy=%b, want data=%h busy=%b",
                   ph, p, rd_data[p*32 +: 32], rd_busy[p], e.data, e.busy);
        end
      end
      step();
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    for (int ph = 0; ph < 5; ph++) begin
      idle();
      set_rd(0, 5'd9);
      set_rd(1, 5'd9);
      case (ph)
        0: begin sb_set = 1'b1; sb_addr = 5'd9; end
        1: set_wr(0, 5'd9, 32'hA5);
        3: begin set_wr(0, 5'd9, 32'h1); set_wr(1, 5'd9, 32'h2); set_rd(1, 5'd10); end
        default: ;
      endcase
      push_reads();
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        e = sbq.pop_front();
        n_tests++;
        if (rd_data[p*32 +: 32] !== e.data || rd_busy[p] !== e.busy) begin
          n_fail++;
          $display("FAIL bypass ph%0d port%0d: data=%h busy=%b, want data=%h busy=%b",
                   ph, p, rd_data[p*32 +: 32], rd_busy[p], e.data, e.busy);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 80; c++) begin
      idle();
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 1) == 1) set_wr(j, 5'($urandom_range(0, 7)), $urandom);
      end
      sb_set  = 1'($urandom_range(0, 1));
      sb_addr = 5'($urandom_range(0, 7));
      set_rd(0, 5'($urandom_range(0, 7)));
      set_rd(1, 5'($urandom_range(0, 7)));
      push_reads();
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        e = sbq.pop_front();
        n_tests++;
        if (rd_data[p*32 +: 32] !== e.data || rd_busy[p] !== e.busy) begin
          n_fail++;
          $display("FAIL back_to_back c%0d port%0d: data=%h busy=%b, want data=%h busy=%b",
                   c, p, rd_data[p*32 +: 32], rd_busy[p], e.data, e.busy);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    idle();
    set_wr(0, 5'd12, 32'h123);
    sb_set  = 1'b1;
    sb_addr = 5'd13;
    step();
    // Reset from READY, sweep up to cnt=10, then reset again mid-sweep.
    for (int rs = 0; rs < 2; rs++) begin
      idle();
      reset  = 1'b1;
      mready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < ((rs == 0) ? 9 : 31); c++) begin
        idle();
        set_wr(0, 5'($urandom_range(1, 8)), 32'hBAD0 + 32'(c));
        set_wr(1, 5'd2, 32'hBAD1);
        sb_set  = 1'b1;
        sb_addr = 5'($urandom_range(1, 31));
        rd_addr = 10'($urandom);
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b0 || rd_data !== 64'd0 || rd_busy !== 2'b00) begin
          n_fail++;
          $display("FAIL reset_mid rs%0d c%0d: ready=%b data=%h busy=%b, want 0/0/0",
                   rs, c, ready, rd_data, rd_busy);
        end
        @(posedge clk);
        #1;
      end
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: ready=%b, want 1", ready);
    end
    @(posedge clk);
    #1;
    mready = 1'b1;
    model_clear();
    for (int r = 0; r < 32; r++) begin
      idle();
      set_rd(0, 5'(r));
      set_rd(1, 5'(r ^ 1));
      push_reads();
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        e = sbq.pop_front();
        n_tests++;
        if (rd_data[p*32 +: 32] !== e.data || rd_busy[p] !== e.busy) begin
          n_fail++;
          $display("FAIL reset_mid_regs r%0d port%0d: data=%h busy=%b, want data=%h busy=%b",
                   r, p, rd_data[p*32 +: 32], rd_busy[p], e.data, e.busy);
        end
      end
      step();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write();
    test_same_addr();
    test_scoreboard();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
